// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream, packs it into
// 32-bit words, writes them to instruction memory from word 0 and releases the core's
// reset only after the whole program has been written and its checksum matches.
module program_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  // One extra bit so the index can reach DEPTH without wrapping into address 0.
  localparam int unsigned IdxW = ADDR_W + 1;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StWrite,
    StCheck,
    StDone,
    StErr
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [IdxW-1:0]   word_idx_q, word_idx_d;
  logic [7:0]        csum_q, csum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              xfer;
  logic              last_word;

  // Stream is accepted only in the states that consume a byte.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StLenHi, StLenLo, StData, StCheck: in_ready = 1'b1;
      default:                           in_ready = 1'b0;
    endcase
  end

  assign xfer      = in_valid && in_ready;
  assign last_word = (16'(word_idx_q) == (len_q - 16'd1));

  // Next-state logic; all outputs except in_ready are computed here and registered.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    csum_d     = csum_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cpu_rst_d  = cpu_rst_q;
    done_d     = done_q;
    error_d    = error_q;

    unique case (state_q)
      StIdle: begin
        state_d = StLenHi;
      end

      StLenHi: begin
        if (xfer) begin
          len_d   = {in_data, len_q[7:0]};
          state_d = StLenLo;
        end
      end

      StLenLo: begin
        if (xfer) begin
          len_d = {len_q[15:8], in_data};
          if ((len_d == 16'd0) || (32'(len_d) > DEPTH)) begin
            state_d = StErr;
            error_d = 1'b1;
          end else begin
            state_d = StData;
          end
        end
      end

      StData: begin
        if (xfer) begin
          // Earlier bytes move up, so the first byte of a word ends in bits [31:24].
          wdata_d    = {wdata_q[23:0], in_data};
          csum_d     = csum_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = StWrite;
            we_d    = 1'b1;
            addr_d  = word_idx_q[ADDR_W-1:0];
          end
        end
      end

      StWrite: begin
        word_idx_d = word_idx_q + IdxW'(1);
        state_d    = last_word ? StCheck : StData;
      end

      StCheck: begin
        if (xfer) begin
          if (in_data == csum_q) begin
            state_d   = StDone;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = StErr;
            error_d = 1'b1;
          end
        end
      end

      StDone, StErr: begin
        if (start) begin
          state_d    = StLenHi;
          cpu_rst_d  = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          word_idx_d = '0;
          byte_cnt_d = '0;
          csum_d     = '0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset drops the write strobe and holds the core in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      csum_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      csum_q     <= csum_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: drives byte streams on the falling edge, samples on
// the falling edge, and keeps its own copy of instruction memory from observed writes.
module tb_program_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  int          n_pass  = 0;
  int          n_total = 0;
  int          we_cnt  = 0;
  int unsigned cyc     = 0;
  logic [7:0]  last_addr;
  logic [31:0] imem [256];

  int          base;
  int unsigned c0;
  logic [7:0]  cs;
  logic [7:0]  s_ok  [11] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                              8'h21, 8'h09, 8'h00, 8'h03, 8'h06};
  logic [7:0]  s_bad [11] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                              8'h21, 8'h09, 8'h00, 8'h03, 8'h07};

  program_loader #(
    .ADDR_W(8),
    .DEPTH (256)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction-memory model: one strobe is high for exactly one falling edge.
  always @(negedge clk) begin
    if (mem_we) begin
      imem[mem_addr] <= mem_wdata;
      we_cnt         <= we_cnt + 1;
      last_addr      <= mem_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the byte was taken.
  task automatic send(input logic [7:0] b);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) @(negedge clk);

    // Reset state with a byte offered.
    chk("rst_cpu_rst",  {31'd0, cpu_rst},  32'd1);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mem_we",   {31'd0, mem_we},   32'd0);
    chk("rst_done",     {31'd0, done},     32'd0);
    chk("rst_error",    {31'd0, error},    32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    in_valid = 1'b0;
    rst      = 1'b1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("lenhi_in_ready", {31'd0, in_ready}, 32'd1);
    c0   = cyc;
    base = we_cnt;

    // Clean 2-word load, no gaps.
    foreach (s_ok[i]) send(s_ok[i]);
    chk("ok_latency", cyc - c0,       32'd13);
    chk("ok_mem0",    imem[0],        32'h20080005);
    chk("ok_mem1",    imem[1],        32'h21090003);
    chk("ok_we_cnt",  we_cnt - base,  32'd2);
    chk("ok_done",    {31'd0, done},     32'd1);
    chk("ok_cpu_rst", {31'd0, cpu_rst},  32'd0);
    chk("ok_ready",   {31'd0, in_ready}, 32'd0);
    chk("ok_error",   {31'd0, error},    32'd0);

    // Bad checksum.
    pulse_start();
    chk("rearm_ready",   {31'd0, in_ready}, 32'd1);
    chk("rearm_done",    {31'd0, done},     32'd0);
    chk("rearm_cpu_rst", {31'd0, cpu_rst},  32'd1);
    imem[0] = 32'h0;
    imem[1] = 32'h0;
    base    = we_cnt;
    foreach (s_bad[i]) send(s_bad[i]);
    chk("bad_we_cnt",  we_cnt - base,     32'd2);
    chk("bad_mem1",    imem[1],           32'h21090003);
    chk("bad_error",   {31'd0, error},    32'd1);
    chk("bad_done",    {31'd0, done},     32'd0);
    chk("bad_cpu_rst", {31'd0, cpu_rst},  32'd1);
    chk("bad_ready",   {31'd0, in_ready}, 32'd0);
    pulse_start();
    chk("bad_rearm_ready", {31'd0, in_ready}, 32'd1);
    chk("bad_rearm_error", {31'd0, error},    32'd0);

    // Zero length.
    base = we_cnt;
    send(8'h00);
    send(8'h00);
    repeat (2) @(negedge clk);
    chk("len0_error", {31'd0, error},    32'd1);
    chk("len0_ready", {31'd0, in_ready}, 32'd0);
    chk("len0_we",    we_cnt - base,     32'd0);

    // Length 257 exceeds depth.
    pulse_start();
    send(8'h01);
    send(8'h01);
    chk("len257_error", {31'd0, error}, 32'd1);
    chk("len257_ready", {31'd0, in_ready}, 32'd0);

    // Maximum length 256.
    pulse_start();
    base = we_cnt;
    cs   = 8'h00;
    send(8'h01);
    send(8'h00);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'(i);
      b1 = ~8'(i);
      b2 = 8'(i) ^ 8'h5A;
      b3 = 8'hC3;
      send(b0); send(b1); send(b2); send(b3);
      cs = cs ^ b0 ^ b1 ^ b2 ^ b3;
    end
    send(cs);
    chk("max_we_cnt",    we_cnt - base,     32'd256);
    chk("max_last_addr", {24'd0, last_addr}, 32'h000000FF);
    chk("max_mem0",      imem[0],           32'h00FF5AC3);
    chk("max_mem255",    imem[255],         32'hFF00A5C3);
    chk("max_done",      {31'd0, done},     32'd1);
    chk("max_addr_hold", {24'd0, mem_addr}, 32'h000000FF);

    // Gaps, ignored start, and WRITE-cycle backpressure.
    pulse_start();
    base = we_cnt;
    send(8'h00);
    send(8'h01);
    send(8'hAB);
    send(8'hCD);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("gap_ready",   {31'd0, in_ready}, 32'd1);
    chk("gap_cpu_rst", {31'd0, cpu_rst},  32'd1);
    chk("gap_we",      we_cnt - base,     32'd0);
    send(8'hEF);
    send(8'h12);
    chk("wr_ready",  {31'd0, in_ready}, 32'd0);
    chk("wr_we",     {31'd0, mem_we},   32'd1);
    chk("wr_addr",   {24'd0, mem_addr}, 32'd0);
    chk("wr_wdata",  mem_wdata,         32'hABCDEF12);
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_wr_we", {31'd0, mem_we}, 32'd0);
    chk("post_wr_wdata", mem_wdata, 32'hABCDEF12);
    send(8'h9B);
    chk("gap_mem0", imem[0],          32'hABCDEF12);
    chk("gap_done", {31'd0, done},    32'd1);
    chk("gap_wecnt", we_cnt - base,   32'd1);

    // Reset in the middle of word 1.
    pulse_start();
    base = we_cnt;
    send(8'h00);
    send(8'h02);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66); send(8'h77);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_we",      {31'd0, mem_we},  32'd0);
    chk("mid_rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("mid_rst_done",    {31'd0, done},    32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_we_cnt", we_cnt - base, 32'd1);
    chk("mid_mem0",   imem[0],       32'h11223344);
    send(8'h00);
    send(8'h01);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    send(8'h22);
    chk("rl_mem0",    imem[0],          32'hDEADBEEF);
    chk("rl_we_cnt",  we_cnt - base,    32'd2);
    chk("rl_last",    {24'd0, last_addr}, 32'd0);
    chk("rl_done",    {31'd0, done},    32'd1);
    chk("rl_cpu_rst", {31'd0, cpu_rst}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Hardware boot loader that receives a program as a byte stream over a valid/ready handshake. It assembles the bytes into 32-bit instruction words and writes them sequentially into the processor's instruction memory starting at word address 0. It holds the processor in reset until a complete, checksum-verified program has been written, then releases it. It is the in-system counterpart of filling instruction memory before the core runs.

Parameters:
ADDR_W, 8, instruction-memory word-address width
DEPTH, 256, instruction-memory depth in words; maximum accepted program length

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-low (0 = reset asserted)
start  input  1  one-cycle re-arm pulse; honoured only in DONE or ERR
in_valid  input  1  byte-stream source has a valid byte
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle; transfer happens when in_valid && in_ready
mem_we  output  1  instruction-memory write strobe, one cycle per word
mem_addr  output  ADDR_W  instruction-memory word address
mem_wdata  output  32  instruction word to write
cpu_rst  output  1  active-high reset to processor core
done  output  1  program loaded and verified
error  output  1  load aborted (bad length or bad checksum)

Behaviour:
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes (each word MSB byte first), then 1 checksum byte = XOR of all 4*N data bytes. Length bytes are excluded from the checksum.
- All outputs are registered except in_ready, which decodes the state.
- In_ready = 1 only in LEN_HI, LEN_LO, DATA, CHECK.
- Reset (rst=0, asynchronous):
  - state = IDLE; cpu_rst = 1.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0, done = 0, error = 0.
  - Byte counter, word index, length and checksum registers = 0.
- IDLE: in_ready = 0; moves unconditionally to LEN_HI on the next clock.
- LEN_HI: on transfer, store len[15:8] and go to LEN_LO.
- LEN_LO: on transfer, store len[7:0].
  - If the resulting length is 0 or greater than DEPTH, go to ERR; no data byte is accepted.
  - Otherwise go to DATA.
- DATA: each transfer shifts the byte into mem_wdata from the MSB side, XORs it into the checksum and increments byte_cnt (0..3).
  - On the 4th byte, go to WRITE.
  - No transfer means all state holds (gaps of any length allowed).
- WRITE (1 cycle): mem_we = 1, mem_addr = word index, in_ready = 0.
  - Next cycle: mem_we = 0 and the word index increments.
  - If the written index was N-1, go to CHECK; otherwise go to DATA.
  - Mem_wdata is stable during the write and holds its value afterwards.
- CHECK: on transfer, compare the byte with the checksum.
  - Equal: go to DONE.
  - Not equal: go to ERR.
- DONE: done = 1, cpu_rst = 0, in_ready = 0. Further stream bytes are not accepted.
- ERR: error = 1, cpu_rst = 1, in_ready = 0. Words already written are not undone.
- start in DONE or ERR:
  - Next state LEN_HI; cpu_rst = 1; done and error clear.
  - Word index, byte counter and checksum clear.
- start in any other state is ignored.
- Latency: a clean N-word load with no stream gaps reaches DONE 5N+3 cycles after leaving IDLE. Cycle count is 2 (length) + 4N (data) + N (WRITE) + 1 (checksum).
- Maximum N = DEPTH; the last write goes to address DEPTH-1 and mem_addr never wraps.
- Asynchronous reset mid-load:
  - mem_we drops immediately.
  - The partial word is discarded and not written.
  - The load restarts from IDLE after reset releases.

Test Plan:
- Reset: hold rst=0 with in_valid=1 -> cpu_rst=1, in_ready=0, mem_we=0, done=0, error=0. After release, 1 cycle IDLE, then in_ready=1.
- Clean 2-word load: stream 00 02 20 08 00 05 21 09 00 03 06 -> mem[0]=0x20080005, mem[1]=0x21090003, exactly 2 mem_we pulses. Then done=1, cpu_rst=0, in_ready=0.
- Bad checksum: same stream with final byte 07 -> both words written, error=1, done=0, cpu_rst stays 1. A start pulse returns in_ready=1 and error=0.
- Length bounds:
  - Stream 00 00 -> ERR, no mem_we.
  - Stream 01 01 (257) -> ERR.
  - Stream 01 00 with 1024 data bytes and correct checksum -> last write at mem_addr=0xFF, then DONE.
- Backpressure and gaps: drop in_valid for 3 cycles after the 2nd byte of a word -> state holds, the word is still assembled correctly. in_ready=0 during each WRITE cycle, and a byte offered then is not consumed.
- Reset mid-load: assert rst after the 3rd data byte of word 1 -> mem_we=0 immediately, no write to address 1. A subsequent full 1-word stream writes mem[0] and reaches DONE.
